// File: rtl/clause_scan_controller.sv
// ---------------------------------------------------------------------------
// clause_scan_controller
//   Runs one unit-propagation pass over clause memory: fetches clauses
//   0..num_clauses-1 one at a time, samples the clause evaluator one cycle
//   after each read, and queues implications from unit clauses in a small
//   FIFO for the assignment stage. A conflicting clause ends the pass early.
//
// Ports
//   clock, reset_n     rising-edge clock, synchronous active-low reset
//   start, num_clauses begin a pass over num_clauses clauses (IDLE/DONE only)
//   abort              cancel the pass and flush queued implications
//   clause_rd_en/addr  clause RAM read strobe and address
//   eval_*             evaluator result for the clause read last cycle
//   impl_valid/var/value, impl_ready   implication FIFO head, pop handshake
//   busy, done         pass in progress, one-cycle end-of-pass pulse
//   conflict, conflict_idx   sticky conflict flag and offending clause index
//   unit_count         implications pushed during this pass (saturating)
// ---------------------------------------------------------------------------
module clause_scan_controller #(
    parameter int NUM_CLAUSE     = 256,
    parameter int CLAUSE_INDEX   = $clog2(NUM_CLAUSE),
    parameter int NUM_VARIABLE   = 128,
    parameter int VARIABLE_INDEX = $clog2(NUM_VARIABLE),
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [CLAUSE_INDEX:0]     num_clauses,
    input  logic                      abort,
    output logic                      clause_rd_en,
    output logic [CLAUSE_INDEX-1:0]   clause_rd_addr,
    input  logic                      eval_unit,
    input  logic [VARIABLE_INDEX-1:0] eval_var,
    input  logic                      eval_value,
    input  logic                      eval_conflict,
    output logic                      impl_valid,
    output logic [VARIABLE_INDEX-1:0] impl_var,
    output logic                      impl_value,
    input  logic                      impl_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      conflict,
    output logic [CLAUSE_INDEX-1:0]   conflict_idx,
    output logic [CLAUSE_INDEX:0]     unit_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]        FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CLAUSE_INDEX:0]   UNIT_MAX  = '1;

    typedef enum logic [2:0] {IDLE, FETCH, EVAL, STALL, DONE} state_t;

    state_t state, state_next;

    logic [CLAUSE_INDEX:0]     num_q;
    logic [CLAUSE_INDEX-1:0]   idx;
    logic [VARIABLE_INDEX-1:0] pend_var;
    logic                      pend_value;

    // Each entry is {variable, value}.
    logic [VARIABLE_INDEX:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [CNT_W-1:0]          fifo_count;

    logic                      pop, space, last;
    logic                      start_pass, push_en, load_pending, advance;
    logic                      set_conflict, enter_done;
    logic [VARIABLE_INDEX-1:0] push_var;
    logic                      push_value;

    assign impl_valid = (fifo_count != '0);
    assign impl_var   = fifo_mem[rd_ptr][VARIABLE_INDEX:1];
    assign impl_value = fifo_mem[rd_ptr][0];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign pop   = impl_valid & impl_ready;
    assign space = (fifo_count != FIFO_FULL) | pop;
    assign last  = ({1'b0, idx} == num_q - (CLAUSE_INDEX+1)'(1));

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned and no latch is inferred.
        state_next     = state;
        clause_rd_en   = 1'b0;
        clause_rd_addr = '0;
        busy           = 1'b0;
        start_pass     = 1'b0;
        push_en        = 1'b0;
        push_var       = eval_var;
        push_value     = eval_value;
        load_pending   = 1'b0;
        advance        = 1'b0;
        set_conflict   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_pass = 1'b1;
                    state_next = (num_clauses == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                busy           = 1'b1;
                clause_rd_en   = 1'b1;
                clause_rd_addr = idx;
                state_next     = EVAL;
            end
            EVAL: begin
                busy = 1'b1;
                if (eval_conflict) begin
                    set_conflict = 1'b1;
                    state_next   = DONE;
                end else if (eval_unit && !space) begin
                    load_pending = 1'b1;
                    state_next   = STALL;
                end else begin
                    push_en = eval_unit;
                    if (last) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            STALL: begin
                busy       = 1'b1;
                push_var   = pend_var;
                push_value = pend_value;
                if (space) begin
                    push_en = 1'b1;
                    if (last) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort wins over everything but reset: no push, no done, no restart.
        if (abort) begin
            state_next   = IDLE;
            start_pass   = 1'b0;
            push_en      = 1'b0;
            load_pending = 1'b0;
            advance      = 1'b0;
            set_conflict = 1'b0;
        end

        // Restarting from DONE with zero clauses re-enters DONE and must pulse.
        enter_done = (state_next == DONE) && ((state != DONE) || start_pass);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: the FIFO storage is reset because impl_var/impl_value
            // read straight from it and must come out of reset as zero.
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            num_q        <= '0;
            idx          <= '0;
            pend_var     <= '0;
            pend_value   <= 1'b0;
            done         <= 1'b0;
            conflict     <= 1'b0;
            conflict_idx <= '0;
            unit_count   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees the
            // pre-edge value of every other, independent of statement order.
            done <= enter_done;

            if (start_pass) begin
                num_q      <= num_clauses;
                idx        <= '0;
                conflict   <= 1'b0;
                unit_count <= '0;
            end
            if (advance) idx <= idx + CLAUSE_INDEX'(1);
            if (set_conflict) begin
                conflict     <= 1'b1;
                conflict_idx <= idx;
            end
            if (load_pending) begin
                pend_var   <= eval_var;
                pend_value <= eval_value;
            end
            if (push_en && (unit_count != UNIT_MAX)) unit_count <= unit_count + (CLAUSE_INDEX+1)'(1);

            if (abort) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push_en) begin
                    fifo_mem[wr_ptr] <= {push_var, push_value};
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push_en, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                    2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clause_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_clause_scan_controller
//   Self-checking bench for clause_scan_controller. A clause table stands in
//   for clause RAM plus evaluator; expected implications are queued when a
//   unit clause is read and compared when the consumer pops the FIFO head.
// ---------------------------------------------------------------------------
module tb_clause_scan_controller;

    typedef struct {
        int          num;
        logic [15:0] unit_mask;
        int          conf_at;
        bit          ready;
        int          exp_units;
        bit          exp_conflict;
        int          exp_cidx;
        int          exp_reads;
        int          exp_lat;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n, start, abort, impl_ready;
    logic [8:0] num_clauses;
    logic       eval_unit, eval_value, eval_conflict;
    logic [6:0] eval_var;
    logic       clause_rd_en, impl_valid, impl_value, busy, done, conflict;
    logic [7:0] clause_rd_addr, conflict_idx;
    logic [6:0] impl_var;
    logic [8:0] unit_count;

    clause_scan_controller dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .num_clauses   (num_clauses),
        .abort         (abort),
        .clause_rd_en  (clause_rd_en),
        .clause_rd_addr(clause_rd_addr),
        .eval_unit     (eval_unit),
        .eval_var      (eval_var),
        .eval_value    (eval_value),
        .eval_conflict (eval_conflict),
        .impl_valid    (impl_valid),
        .impl_var      (impl_var),
        .impl_value    (impl_value),
        .impl_ready    (impl_ready),
        .busy          (busy),
        .done          (done),
        .conflict      (conflict),
        .conflict_idx  (conflict_idx),
        .unit_count    (unit_count)
    );

    always #5 clock = ~clock;

    vec_t       vecs [6];
    bit         tb_unit [256];
    bit         tb_conf [256];
    logic [7:0] sb_q [$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, busy_cnt = 0, done_cnt = 0, rd_cnt = 0, pops = 0;
    int start_cyc = 0, done_cyc = 0;
    int rd0, busy0, done0, pops0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_table(input logic [15:0] mask, input int conf_at);
        for (int i = 0; i < 256; i++) begin
            tb_unit[i] = (i < 16) ? mask[i] : 1'b0;
            tb_conf[i] = (i == conf_at);
        end
    endtask

    task automatic snapshot();
        rd0   = rd_cnt;
        busy0 = busy_cnt;
        done0 = done_cnt;
        pops0 = pops;
    endtask

    task automatic pulse_start(input int num);
        tick();
        start       = 1'b1;
        num_clauses = 9'(num);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (done_cnt != done0) got = 1'b1;
        end
        check(name, 32'(got), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (impl_valid || sb_q.size() != 0); k++) tick();
        tick();
        tick();
    endtask

    task automatic run_vector(input int k);
        vec_t v = vecs[k];
        set_table(v.unit_mask, v.conf_at);
        impl_ready = v.ready;
        snapshot();
        pulse_start(v.num);
        wait_done($sformatf("v%0d_done_seen", k), 1200);
        drain();
        check($sformatf("v%0d_latency", k), 32'(done_cyc - start_cyc), 32'(v.exp_lat));
        check($sformatf("v%0d_unit_count", k), 32'(unit_count), 32'(v.exp_units));
        check($sformatf("v%0d_conflict", k), 32'(conflict), 32'(v.exp_conflict));
        if (v.exp_conflict) check($sformatf("v%0d_conflict_idx", k), 32'(conflict_idx), 32'(v.exp_cidx));
        check($sformatf("v%0d_reads", k), 32'(rd_cnt - rd0), 32'(v.exp_reads));
        check($sformatf("v%0d_busy_cycles", k), 32'(busy_cnt - busy0), 32'(v.exp_lat - 1));
        check($sformatf("v%0d_done_pulses", k), 32'(done_cnt - done0), 1);
        check($sformatf("v%0d_delivered", k), 32'(pops - pops0), 32'(v.exp_units));
        check($sformatf("v%0d_sb_empty", k), 32'(sb_q.size()), 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        impl_ready    = 1'b0;
        num_clauses   = '0;
        eval_unit     = 1'b0;
        eval_var      = '0;
        eval_value    = 1'b0;
        eval_conflict = 1'b0;
        set_table(16'h0000, -1);

        //          num  unit_mask  conf rdy units conf cidx reads lat
        vecs[0] = '{3,   16'h0002,  -1,  1,  1,    0,   0,   3,    7};
        vecs[1] = '{0,   16'h0000,  -1,  1,  0,    0,   0,   0,    1};
        vecs[2] = '{1,   16'h0001,   0,  1,  0,    1,   0,   1,    3};
        vecs[3] = '{6,   16'h0005,   3,  1,  2,    1,   3,   4,    9};
        vecs[4] = '{5,   16'h001F,  -1,  1,  5,    0,   0,   5,    11};
        vecs[5] = '{256, 16'h8001,  -1,  1,  2,    0,   0,   256,  513};

        fork
            // Clause RAM / evaluator model, consumer-side scoreboard, counters.
            forever begin
                logic [7:0] a;
                logic [7:0] exp_head;
                @(negedge clock);
                cyc++;
                if (busy) busy_cnt++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (!reset_n || abort) begin
                    sb_q.delete();
                end else begin
                    if (start) start_cyc = cyc;
                    if (impl_valid && impl_ready) begin
                        pops++;
                        if (sb_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL impl_unexpected: got %0d/%0d, expected no entry", impl_var, impl_value);
                        end else begin
                            exp_head = sb_q.pop_front();
                            check("impl_head", 32'({impl_var, impl_value}), 32'(exp_head));
                        end
                    end
                    if (clause_rd_en) begin
                        rd_cnt++;
                        a             = clause_rd_addr;
                        eval_unit     = tb_unit[a];
                        eval_conflict = tb_conf[a];
                        eval_var      = 7'(a + 8'd4);
                        eval_value    = a[0];
                        if (tb_unit[a] && !tb_conf[a]) sb_q.push_back({eval_var, eval_value});
                    end
                end
            end

            begin
                #200000;
                n_tests++;
                n_fail++;
                $display("FAIL watchdog: got timeout, expected completion");
            end

            begin
                // Reset state
                tick(); tick(); tick();
                reset_n = 1'b1;
                check("rst_busy", 32'(busy), 0);
                check("rst_impl_valid", 32'(impl_valid), 0);
                check("rst_done", 32'(done), 0);
                check("rst_unit_count", 32'(unit_count), 0);
                check("rst_rd_en", 32'(clause_rd_en), 0);

                // Table-driven passes
                for (int k = 0; k < 6; k++) run_vector(k);

                // abort and start together from DONE: abort wins
                snapshot();
                tick();
                start       = 1'b1;
                abort       = 1'b1;
                num_clauses = 9'd3;
                tick();
                start = 1'b0;
                abort = 1'b0;
                tick(); tick(); tick();
                check("abst_reads", 32'(rd_cnt - rd0), 0);
                check("abst_done", 32'(done_cnt - done0), 0);
                check("abst_busy", 32'(busy), 0);
                check("abst_unit_hold", 32'(unit_count), 2);

                // 12 unit clauses into an 8-deep FIFO with consumer stalled
                set_table(16'h0FFF, -1);
                impl_ready = 1'b0;
                snapshot();
                pulse_start(12);
                for (int k = 0; k < 25; k++) tick();
                check("stall_unit_count", 32'(unit_count), 8);
                check("stall_busy", 32'(busy), 1);
                check("stall_reads", 32'(rd_cnt - rd0), 9);
                check("stall_head", 32'({impl_var, impl_value}), 32'({7'd4, 1'b0}));
                tick(); tick(); tick();
                check("stall_head_stable", 32'({impl_var, impl_value}), 32'({7'd4, 1'b0}));
                check("stall_no_done", 32'(done_cnt - done0), 0);
                impl_ready = 1'b1;
                wait_done("stall_done_seen", 200);
                drain();
                check("stall_unit_final", 32'(unit_count), 12);
                check("stall_delivered", 32'(pops - pops0), 12);
                check("stall_sb_empty", 32'(sb_q.size()), 0);
                check("stall_done_pulses", 32'(done_cnt - done0), 1);

                // abort during EVAL of clause 2 with two entries queued
                set_table(16'h0007, -1);
                impl_ready = 1'b0;
                snapshot();
                pulse_start(6);
                for (int k = 0; k < 5; k++) tick();
                check("abort_pre_busy", 32'(busy), 1);
                check("abort_pre_rd_en", 32'(clause_rd_en), 0);
                check("abort_pre_units", 32'(unit_count), 2);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_busy", 32'(busy), 0);
                check("abort_impl_valid", 32'(impl_valid), 0);
                check("abort_unit_hold", 32'(unit_count), 2);
                for (int k = 0; k < 4; k++) tick();
                check("abort_no_done", 32'(done_cnt - done0), 0);
                check("abort_reads", 32'(rd_cnt - rd0), 3);

                // reset mid-STALL, then a clean pass
                set_table(16'h0FFF, -1);
                impl_ready = 1'b0;
                pulse_start(12);
                for (int k = 0; k < 25; k++) tick();
                check("rst2_pre_units", 32'(unit_count), 8);
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
                check("rst2_rd_en", 32'(clause_rd_en), 0);
                check("rst2_rd_addr", 32'(clause_rd_addr), 0);
                check("rst2_impl_valid", 32'(impl_valid), 0);
                check("rst2_impl_var", 32'(impl_var), 0);
                check("rst2_impl_value", 32'(impl_value), 0);
                check("rst2_busy", 32'(busy), 0);
                check("rst2_done", 32'(done), 0);
                check("rst2_conflict", 32'(conflict), 0);
                check("rst2_conflict_idx", 32'(conflict_idx), 0);
                check("rst2_unit_count", 32'(unit_count), 0);
                run_vector(0);
            end
        join_any

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
